// File: rtl/uart_cts_tx.sv
// uart_cts_tx: byte-queued UART transmitter (8N1) with CTS flow control.
//
// Bytes offered on uart_data are pushed into a small FIFO. A serializer pops
// them and shifts them out on uart_tx: one start bit, eight data bits sent
// LSB first, and one stop bit. Each bit lasts CLKS_PER_BIT clocks. uart_cts
// is sampled only between bytes, so a byte that has started always finishes.
//
// Ports:
//   clock          - single clock; all logic is on its rising edge
//   reset          - asynchronous, active-high reset
//   uart_data      - byte offered for transmission
//   send_uart_data - level request; held high with uart_data stable
//   uart_cts       - remote side ready to receive (high = may start a byte)
//   uart_tx        - serial line, idle high
//   uart_data_sent - one-cycle pulse: the byte was accepted into the queue
//   tx_busy        - queue non-empty or a frame in flight
//   fifo_count     - current queue occupancy
//   fsm_state      - serializer state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Request handshake: the producer raises send_uart_data and holds uart_data
// stable. A byte is taken on an edge where the request is high, the block is
// armed and the queue is not full. uart_data_sent pulses in the next cycle.
// Taking a byte disarms the block. It re-arms on any edge that samples the
// request low, so one request level produces exactly one enqueue.
module uart_cts_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     uart_data,
    input  logic                           send_uart_data,
    input  logic                           uart_cts,
    output logic                           uart_tx,
    output logic                           uart_data_sent,
    output logic                           tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [1:0]                     fsm_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          armed;
    logic          accept;
    logic          deq;
    logic          bit_done;
    logic          queue_ready;

    // Fullness uses the count from before the edge. A dequeue on the same edge
    // does not free a slot for this edge.
    assign accept      = send_uart_data && armed && (fifo_count != DEPTH_C);
    assign queue_ready = (fifo_count != '0) && uart_cts;
    assign bit_done    = (baud_cnt == BAUD_LAST);
    assign tx_busy     = !((state == IDLE) && (fifo_count == '0));
    assign fsm_state   = state;

    // Next-state logic, dequeue strobe and line level.
    always_comb begin
        state_next = state;
        deq        = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            IDLE: begin
                if (queue_ready) begin
                    deq        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                uart_tx = shift[bit_idx];
                if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    // Chain directly into the next start bit when possible.
                    if (queue_ready) begin
                        deq        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            if (state == IDLE || bit_done) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + BW'(1);
            if (state == START)                 bit_idx <= 3'd0;
            else if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
            if (deq) shift <= mem[rd_ptr];
        end
    end

    // Queue bookkeeping and request handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            armed          <= 1'b1;
            uart_data_sent <= 1'b0;
        end else begin
            uart_data_sent <= accept;
            if (accept)              armed <= 1'b0;
            else if (!send_uart_data) armed <= 1'b1;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (deq)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, deq})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage array; the pointers and count carry all reset state.
    always_ff @(posedge clock) begin
        if (!reset && accept) mem[wr_ptr] <= uart_data;
    end

endmodule

// File: tb/tb_uart_cts_tx.sv
// tb_uart_cts_tx: directed testbench for uart_cts_tx with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Inputs are driven and outputs are sampled 1 ns after each
// rising edge. Expected line levels are built from the byte under test:
// start=0, data bits LSB first, stop=1, with each bit lasting 4 cycles.
module tb_uart_cts_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] uart_data;
    logic       send_uart_data;
    logic       uart_cts;
    logic       uart_tx;
    logic       uart_data_sent;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;

    uart_cts_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .uart_data      (uart_data),
        .send_uart_data (send_uart_data),
        .uart_cts       (uart_cts),
        .uart_tx        (uart_tx),
        .uart_data_sent (uart_data_sent),
        .tx_busy        (tx_busy),
        .fifo_count     (fifo_count),
        .fsm_state      (fsm_state)
    );

    always #5 clock = ~clock;

    // Count acceptance pulses mid-cycle, away from the active edge.
    always @(negedge clock) if (uart_data_sent === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Offer one byte and wait for its single-cycle acknowledgement. Then drop
    // the request for one edge so the block re-arms.
    task automatic send_byte(input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        uart_data      = b;
        send_uart_data = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (uart_data_sent === 1'b1) seen = 1'b1;
        end
        check($sformatf("sent_pulse_%02h", b), 32'(seen), 32'd1);
        send_uart_data = 1'b0;
        tick();
        check($sformatf("sent_one_cycle_%02h", b), 32'(uart_data_sent), 32'd0);
    endtask

    task automatic wait_start(input int max_cycles);
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("start_seen", 32'(uart_tx), 32'd0);
    endtask

    // The call must begin on the first start-bit cycle. It checks 40 cycles
    // and returns on the first cycle after the stop bit. A drop_at value of
    // 0..39 lowers uart_cts at that cycle of the frame.
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            if (i == drop_at) uart_cts = 1'b0;
            check($sformatf("frame_%02h_cyc%0d", b, i), 32'(uart_tx), 32'(bits[i/4]));
            tick();
        end
    endtask

    initial begin
        int pulses;
        int maxc;
        int base;

        reset          = 1'b1;
        uart_data      = 8'h00;
        send_uart_data = 1'b0;
        uart_cts       = 1'b0;

        // Reset state
        @(posedge clock);
        #1;
        check("rst_tx",    32'(uart_tx),        32'd1);
        check("rst_sent",  32'(uart_data_sent), 32'd0);
        check("rst_busy",  32'(tx_busy),        32'd0);
        check("rst_count", 32'(fifo_count),     32'd0);
        check("rst_state", 32'(fsm_state),      32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single byte 0xA5
        uart_cts = 1'b1;
        send_byte(8'hA5);
        wait_start(5);
        check_frame(8'hA5, -1);
        check("a5_busy_after",  32'(tx_busy),    32'd0);
        check("a5_count_after", 32'(fifo_count), 32'd0);

        // Request held high for 10 cycles yields one enqueue
        uart_cts       = 1'b0;
        uart_data      = 8'h3C;
        send_uart_data = 1'b1;
        pulses = 0;
        maxc   = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (uart_data_sent === 1'b1) pulses++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        check("held_pulses",    32'(pulses), 32'd1);
        check("held_max_count", 32'(maxc),   32'd1);
        send_uart_data = 1'b0;
        tick();
        uart_cts = 1'b1;
        wait_start(5);
        check_frame(8'h3C, -1);

        // Full queue holds off the fifth byte
        uart_cts = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("full_count", 32'(fifo_count), 32'd4);
        base = pulse_cnt;
        uart_data      = 8'h05;
        send_uart_data = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("full_no_pulse_%0d", n), 32'(uart_data_sent), 32'd0);
        end
        check("full_count_held", 32'(fifo_count), 32'd4);
        uart_cts = 1'b1;
        tick();
        check("full_deq_count", 32'(fifo_count),     32'd3);
        check("full_deq_nosent", 32'(uart_data_sent), 32'd0);
        check_frame(8'h01, -1);
        check_frame(8'h02, -1);
        check_frame(8'h03, -1);
        check_frame(8'h04, -1);
        check_frame(8'h05, -1);
        check("full_pulses", 32'(pulse_cnt - base), 32'd1);
        check("full_busy_after", 32'(tx_busy), 32'd0);
        send_uart_data = 1'b0;
        tick();

        // CTS dropped mid-frame: the current frame finishes, the next waits
        uart_cts = 1'b0;
        send_byte(8'h5A);
        send_byte(8'hC3);
        check("cts_count2", 32'(fifo_count), 32'd2);
        uart_cts = 1'b1;
        tick();
        check("cts_count1", 32'(fifo_count), 32'd1);
        check_frame(8'h5A, 10);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("cts_wait_tx_%0d", n), 32'(uart_tx), 32'd1);
            tick();
        end
        check("cts_wait_count", 32'(fifo_count), 32'd1);
        check("cts_wait_busy",  32'(tx_busy),    32'd1);
        check("cts_wait_state", 32'(fsm_state),  32'd0);
        uart_cts = 1'b1;
        tick();
        check_frame(8'hC3, -1);
        check("cts_busy_after", 32'(tx_busy), 32'd0);

        // Reset during DATA bit 3
        uart_cts = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        uart_cts = 1'b1;
        tick();
        for (int n = 0; n < 17; n++) tick();
        check("mid_bit3_low", 32'(uart_tx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tx",    32'(uart_tx),    32'd1);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_busy",  32'(tx_busy),    32'd0);
        check("arst_state", 32'(fsm_state),  32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("post_rst_tx_%0d", n), 32'(uart_tx), 32'd1);
            check($sformatf("post_rst_cnt_%0d", n), 32'(fifo_count), 32'd0);
        end
        send_byte(8'h81);
        wait_start(5);
        check_frame(8'h81, -1);
        for (int n = 0; n < 12; n++) begin
            check($sformatf("post_81_idle_%0d", n), 32'(uart_tx), 32'd1);
            tick();
        end
        check("post_81_busy", 32'(tx_busy), 32'd0);

        // Simultaneous enqueue and dequeue with two bytes queued
        uart_cts = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        check("simul_pre_count", 32'(fifo_count), 32'd2);
        uart_data      = 8'h33;
        send_uart_data = 1'b1;
        uart_cts       = 1'b1;
        tick();
        check("simul_count", 32'(fifo_count),     32'd2);
        check("simul_sent",  32'(uart_data_sent), 32'd1);
        send_uart_data = 1'b0;
        check_frame(8'h11, -1);
        check_frame(8'h22, -1);
        check_frame(8'h33, -1);
        check("simul_busy_after", 32'(tx_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
